serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 168 ++++++++++++++++
 tb/tb_serial_add_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_add_arbiter                                         |
// | Description : Two requesters share one 1-bit full-adder slice. The       |
// |               round-robin winner's operands are captured at grant and    |
// |               added LSB first, one bit per cycle. The result is then     |
// |               presented for one cycle with DONE.                         |
// | Ports       : CLK, RST           clock / synchronous active-high reset   |
// |               REQ0,A0,B0,CIN0    requester 0 request and operands        |
// |               REQ1,A1,B1,CIN1    requester 1 request and operands        |
// |               GNT[1:0]           one-hot grant, high only while adding   |
// |               BUSY               high whenever not idle                  |
// |               DONE, DONE_ID      result-valid pulse and served index     |
// |               SUM, COUT          result, held until the next DONE        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             CIN0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic             CIN1,
    output logic [1:0]       GNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             DONE_ID,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);

    // Counter wide enough to hold WIDTH-1 even when WIDTH is 1.
    localparam int              CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_next;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_last;
    logic             r_owner;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done_id;
    logic             w_any_req;
    logic             w_winner;
    logic             w_bit;
    logic             w_carry;
    logic             w_last_bit;

    assign w_any_req  = REQ0 | REQ1;
    assign w_last_bit = (r_cnt == c_LAST);

    // Round-robin: a lone requester wins; on contention the one not served
    // last wins.
    always_comb begin
        if (REQ0 && REQ1) begin
            w_winner = ~r_last;
        end else begin
            w_winner = REQ1;
        end
    end

    // The shared full-adder slice works on the LSBs of the operand shifters.
    assign w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_b[0] & r_carry) | (r_carry & r_a[0]);

    // New bits enter at the MSB, so after WIDTH shifts the first (LSB) bit
    // has reached bit 0.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_bit;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req)  w_next_state = c_ADD;
            c_ADD:   if (w_last_bit) w_next_state = c_FIN;
            c_FIN:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        GNT  = 2'b00;
        BUSY = (r_state != c_IDLE);
        DONE = (r_state == c_FIN);
        if (r_state == c_ADD) begin
            GNT = r_owner ? 2'b10 : 2'b01;
        end
    end

    assign SUM     = r_sum;
    assign COUT    = r_cout;
    assign DONE_ID = r_done_id;

    // Datapath: operand capture at grant, bit-serial add, result commit on
    // the edge that enters FIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        r_a     <= w_winner ? A1   : A0;
                        r_b     <= w_winner ? B1   : B0;
                        r_carry <= w_winner ? CIN1 : CIN0;
                        r_cnt   <= '0;
                    end
                end
                c_ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last_bit) begin
                        r_sum     <= w_res_next;
                        r_cout    <= w_carry;
                        r_done_id <= r_owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_add_arbiter                                      |
// | Description : Self-checking bench for serial_add_arbiter. A transaction- |
// |               level model (grant countdown + integer addition) checks    |
// |               the WIDTH=8 instance every cycle; directed scenarios pin   |
// |               literal results; a WIDTH=1 instance is checked directly.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_serial_add_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, cin0, cin1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy, done, done_id, cout;
    logic [W-1:0] sum;

    logic         rst_s, req_s, a_s, b_s, cin_s;
    logic [1:0]   gnt_s;
    logic         busy_s, done_s, done_id_s, sum_s, cout_s;
    logic         zero1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .A0(a0), .B0(b0), .CIN0(cin0),
        .REQ1(req1), .A1(a1), .B1(b1), .CIN1(cin1),
        .GNT(gnt), .BUSY(busy), .DONE(done), .DONE_ID(done_id),
        .SUM(sum), .COUT(cout)
    );

    assign zero1 = 1'b0;

    serial_add_arbiter #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst_s),
        .REQ0(req_s), .A0(a_s), .B0(b_s), .CIN0(cin_s),
        .REQ1(zero1), .A1(zero1), .B1(zero1), .CIN1(zero1),
        .GNT(gnt_s), .BUSY(busy_s), .DONE(done_s), .DONE_ID(done_id_s),
        .SUM(sum_s), .COUT(cout_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model -------------------
    // m_left counts remaining granted cycles; m_fin marks the result cycle.
    bit           m_valid = 0;
    int           m_left;
    bit           m_fin;
    bit           m_last;
    bit           m_owner;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum;
    bit           m_cout;
    bit           m_id;

    task automatic model_check();
        logic [1:0] eg;
        eg = (m_left > 0) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("model_gnt",     gnt,     eg);
        chk("model_busy",    busy,    (m_left > 0) || m_fin);
        chk("model_done",    done,    m_fin);
        chk("model_sum",     sum,     m_sum);
        chk("model_cout",    cout,    m_cout);
        chk("model_done_id", done_id, m_id);
    endtask

    // Advance using the inputs that the coming rising edge will sample.
    task automatic model_step();
        bit w;
        if (rst) begin
            m_valid = 1;
            m_left = 0; m_fin = 0; m_last = 1;
            m_sum = '0; m_cout = 0; m_id = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_fin  = 1;
                m_sum  = m_pend[W-1:0];
                m_cout = m_pend[W];
                m_id   = m_owner;
            end
        end else if (req0 || req1) begin
            w       = (req0 && req1) ? !m_last : req1;
            m_last  = w;
            m_owner = w;
            m_pend  = w ? ({1'b0, a1} + {1'b0, b1} + (W+1)'(cin1))
                        : ({1'b0, a0} + {1'b0, b0} + (W+1)'(cin0));
            m_left  = W;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) model_check();
            model_step();
        end
    end

    // ------------------------------ helpers --------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; req0 = 0; req1 = 0;
        tick(); rst = 1'b0;
    endtask

    // Single requester-0 operation; optionally zero A0 at ADD cycle corrupt_at.
    task automatic op0(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int corrupt_at, input logic [W-1:0] es, input logic ec);
        int  g = 0;
        bit  seen = 0;
        tick(); req0 = 1; req1 = 0; a0 = a; b0 = b; cin0 = c;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) req0 = 0;
            if (i == corrupt_at) a0 = '0;
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("lit_done_cycle", i, W + 1);
                break;
            end
            if (gnt == 2'b01) g++;
        end
        chk("lit_done_seen", seen, 1);
        chk("lit_gnt_cycles", g, W);
        chk("lit_done_id", done_id, 0);
        chk("lit_sum", sum, es);
        chk("lit_cout", cout, ec);
    endtask

    // ------------------------------ stimulus --------------------------------
    initial begin
        int        ids[3];
        int        sums[3];
        int        at[3];
        int        k;
        int        g;
        bit        seen;

        rst = 1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; cin0 = 0; cin1 = 0;
        rst_s = 1; req_s = 0; a_s = 0; b_s = 0; cin_s = 0;
        tick(); tick(); rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_done_id", done_id, 0);

        op0(8'h5A, 8'h3C, 0, 0, 8'h96, 0);
        op0(8'hFF, 8'h01, 0, 0, 8'h00, 1);
        op0(8'hFF, 8'hFF, 1, 0, 8'hFF, 1);
        op0(8'h5A, 8'h3C, 0, 3, 8'h96, 0);   // operand change mid-add ignored

        // Contention with both requests held
        do_reset();
        req0 = 1; req1 = 1; a0 = 8'h01; b0 = 8'h02; a1 = 8'h10; b1 = 8'h20; cin0 = 0; cin1 = 0;
        k = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (done) begin
                ids[k] = done_id; sums[k] = sum; at[k] = cyc; k++;
            end
        end
        tick(); req0 = 0; req1 = 0;
        chk("rr_count", k, 3);
        if (k == 3) begin
            chk("rr_id0", ids[0], 0);  chk("rr_sum0", sums[0], 32'h03);
            chk("rr_id1", ids[1], 1);  chk("rr_sum1", sums[1], 32'h30);
            chk("rr_id2", ids[2], 0);  chk("rr_sum2", sums[2], 32'h03);
            chk("rr_gap01", at[1] - at[0], W + 2);
            chk("rr_gap12", at[2] - at[1], W + 2);
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);

        // Reset in the middle of an add
        do_reset();
        tick(); req0 = 1; a0 = 8'h5A; b0 = 8'h3C; cin0 = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) req0 = 0;
        end
        rst = 1;
        tick(); rst = 0; req0 = 1; req1 = 1;
        @(negedge clk);
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_winner", gnt, 2'b01);
        tick(); req0 = 0; req1 = 0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);

        // WIDTH=1 instance
        tick(); rst_s = 0; req_s = 1; a_s = 1; b_s = 1; cin_s = 1;
        g = 0; seen = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) req_s = 0;
            @(negedge clk);
            if (done_s) begin
                seen = 1;
                chk("w1_done_cycle", i, 2);
                break;
            end
            if (gnt_s == 2'b01) g++;
        end
        chk("w1_done_seen", seen, 1);
        chk("w1_gnt_cycles", g, 1);
        chk("w1_sum", sum_s, 1);
        chk("w1_cout", cout_s, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst  = ($urandom_range(0, 79) == 0);
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
            a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
        end
        tick(); rst = 0; req0 = 0; req1 = 0;
        for (int i = 0; i < 2 * W + 6; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
